vdp99_vram_sched: RTL and testbench
===================================

Name: vdp99_vram_sched

Overview:
- Pixel-clock-domain VRAM access scheduler and CPU-port sequencer for the vdp99 VDP.
- Decodes the synchronized CPU port ticks: two-byte mode-port protocol, address auto-increment, read-ahead buffer and register writes.
- Arbitrates the single VRAM port between display fetch (absolute priority) and the pending CPU access.
- Sits between the CPU/pxclk synchronizer and the VRAM/renderer inside the VDP.

Parameters:
- ADDR_W, 14, VRAM address width; the address counter wraps modulo 2^ADDR_W.

Ports:
- pxclk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_tick  in  1  one-cycle CPU write strobe, already synchronized.
- rd_tick  in  1  one-cycle CPU read strobe, already synchronized.
- mode  in  1  port select, valid during a tick: 0=data, 1=mode/status.
- din  in  8  CPU write data, valid during wr_tick.
- dout  out  8  CPU read data; stable between ticks.
- status_in  in  8  status byte from the renderer.
- status_rd  out  1  one-cycle pulse when status is read; the renderer clears its flags on it.
- reg_we  out  1  one-cycle register write strobe.
- reg_num  out  3  register index.
- reg_data  out  8  register value.
- disp_req  in  1  display fetch request; serviced in the same cycle.
- disp_addr  in  ADDR_W  display fetch address.
- disp_valid  out  1  vram_rdata holds display data this cycle (disp_req delayed by 1).
- vram_addr  out  ADDR_W  VRAM address.
- vram_we  out  1  VRAM write enable.
- vram_wdata  out  8  VRAM write data.
- vram_rdata  in  8  VRAM read data; synchronous read, 1-cycle latency.
- cpu_busy  out  1  a CPU VRAM access is pending.
- overrun  out  1  one-cycle pulse when a data-port tick is dropped.

Behaviour:
- Reset (async assert; sync release on pxclk):
  - addr=0, tmp=0, readahead=0, latch=0, pend=IDLE.
  - dout=0; status_rd, reg_we, vram_we, disp_valid, overrun, cpu_busy all 0; reg_num=0, reg_data=0.
- Reset mid-operation aborts any pending access. No VRAM write is issued after reset asserts.
- wr_tick and rd_tick together: the write is processed and the read is ignored.
- Mode write, latch=0: tmp<=din, latch<=1.
- Mode write, latch=1: latch<=0, then by din:
  - din[7]=1: register write. reg_num<=din[2:0], reg_data<=tmp, reg_we=1 next cycle.
  - din[7:6]=00: addr<={din[5:0],tmp} (upper bits truncated to ADDR_W). pend<=READ (read-ahead).
  - din[7:6]=01: addr<={din[5:0],tmp}. No read.
- Mode read:
  - dout<=status_in at the next edge; status_rd=1 for 1 cycle; latch<=0.
  - Mode reads never touch VRAM or pend.
- Data write:
  - latch<=0.
  - readahead<=din (TMS9918 semantics); dout follows.
  - pend<=WRITE with wdata=din and waddr=addr.
  - addr<=addr+1 immediately.
- Data read:
  - latch<=0.
  - dout already holds readahead and is not changed by the tick.
  - pend<=READ at addr; addr<=addr+1 after issue.
- Address wrap: all 1s increments to 0.
- Pending state machine IDLE/WRITE/READ:
  - cpu_busy=(pend!=IDLE).
  - On a cycle with disp_req=0, the pending access is granted.
  - WRITE: vram_we=1, vram_addr=waddr, vram_wdata=wdata. pend<=IDLE.
  - READ: vram_addr=addr. At the next edge pend<=RDWAIT. In RDWAIT, readahead<=vram_rdata, dout<=vram_rdata, pend<=IDLE (RDWAIT counts as busy).
  - A data-port tick arriving while cpu_busy=1 is dropped: no state change, overrun=1 for 1 cycle.
  - Mode-port ticks while busy are accepted. A set-address arriving while busy leaves the old pending access untouched and is then dropped with overrun.
- Arbitration:
  - disp_req=1: vram_addr=disp_addr, vram_we=0, and the CPU waits with no limit.
  - disp_valid<=disp_req registered.
  - RDWAIT captures vram_rdata regardless of disp_req, because its issue cycle was the CPU's.
- Latency, uncontended: a tick at cycle T is granted at T+1.
  - Write lands at T+1.
  - Read data reaches dout at T+2 edge; cpu_busy falls after T+2.

Test Plan:
- Reset, then mode writes 0x34 and 0x12 (read-ahead): addr=0x1234. VRAM[0x1234]=0xAB reaches dout 2 cycles after grant; cpu_busy 1 for 2 cycles. A following data read returns 0xAB with addr=0x1235.
- Mode writes 0x07 then 0x87: reg_we pulses once with reg_num=7 and reg_data=0x07. latch returns to 0; addr is unchanged.
- Set-address 0x3FFF (writes 0xFF, 0x7F), then data writes 0x11 and 0x22 spaced 4 cycles apart: VRAM[0x3FFF]=0x11, VRAM[0x0000]=0x22, dout=0x22.
- Hold disp_req=1 for 10 cycles while a data write is pending: vram_we stays 0 and disp_valid tracks disp_req delayed by 1. The write issues in the first cycle disp_req=0.
- Two data writes 1 cycle apart with disp_req=1: second is dropped with overrun pulsed; only the first lands; addr advanced by 1.
- Single mode write 0x55 then a mode read with status_in=0x80: dout=0x80, status_rd pulses, latch is cleared. The next two mode writes form a fresh pair. Assert reset_n low mid-pending-write: no vram_we, and all outputs return to reset values.

Source files
------------

// File: rtl/vdp99_vram_sched.sv
// vdp99_vram_sched
//
// Pixel-clock VRAM access scheduler and CPU-port sequencer for the vdp99 VDP.
// It decodes the synchronized CPU port ticks: the two-byte mode-port protocol,
// address auto-increment, the read-ahead buffer and register writes. It also
// arbitrates the single VRAM port. Display fetch always wins. The one pending
// CPU access is issued on the first cycle without a display request.
//
// Ports:
//   pxclk, reset_n         pixel clock; asynchronous active-low reset
//   wr_tick, rd_tick       synchronized one-cycle CPU strobes
//   mode                   0 = data port, 1 = mode/status port
//   din                    CPU write data
//   dout                   CPU read data (read-ahead buffer or status)
//   status_in, status_rd   renderer status byte and read-acknowledge pulse
//   reg_we/num/data        register write strobe, index and value
//   disp_req, disp_addr    display fetch request (same-cycle service)
//   disp_valid             vram_rdata carries display data this cycle
//   vram_addr/we/wdata     VRAM port; vram_rdata has 1-cycle read latency
//   cpu_busy               a CPU VRAM access is pending
//   overrun                a data-port tick was dropped while busy

module vdp99_vram_sched #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              pxclk,
    input  logic              reset_n,
    input  logic              wr_tick,
    input  logic              rd_tick,
    input  logic              mode,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [2:0]        reg_num,
    output logic [7:0]        reg_data,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    output logic              cpu_busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        PendIdle,
        PendWrite,
        PendRead,
        PendRdWait
    } pend_e;

    pend_e             pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        tmp_q;
    logic [7:0]        readahead_q;
    logic              latch_q;
    logic [7:0]        dout_q;
    logic              status_rd_q;
    logic              reg_we_q;
    logic [2:0]        reg_num_q;
    logic [7:0]        reg_data_q;
    logic              disp_valid_q;
    logic              overrun_q;

    logic              busy;
    logic [13:0]       set_addr_full;
    logic [ADDR_W-1:0] set_addr;
    logic [ADDR_W-1:0] addr_inc;

    assign busy          = (pend_q != PendIdle);
    assign set_addr_full = {din[5:0], tmp_q};
    assign set_addr      = ADDR_W'(set_addr_full);
    assign addr_inc      = addr_q + ADDR_W'(1);

    // Combinational VRAM port: display fetch is serviced in the cycle it is requested.
    always_comb begin
        vram_addr = addr_q;
        vram_we   = 1'b0;
        if (disp_req) begin
            vram_addr = disp_addr;
        end else begin
            unique case (pend_q)
                PendWrite: begin
                    vram_addr = waddr_q;
                    vram_we   = 1'b1;
                end
                PendRead:   vram_addr = addr_q;
                default:    vram_addr = addr_q;
            endcase
        end
    end

    assign vram_wdata = wdata_q;
    assign cpu_busy   = busy;
    assign dout       = dout_q;
    assign status_rd  = status_rd_q;
    assign reg_we     = reg_we_q;
    assign reg_num    = reg_num_q;
    assign reg_data   = reg_data_q;
    assign disp_valid = disp_valid_q;
    assign overrun    = overrun_q;

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= PendIdle;
            addr_q       <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            tmp_q        <= '0;
            readahead_q  <= '0;
            latch_q      <= 1'b0;
            dout_q       <= '0;
            status_rd_q  <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_num_q    <= '0;
            reg_data_q   <= '0;
            disp_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            status_rd_q  <= 1'b0;
            reg_we_q     <= 1'b0;
            overrun_q    <= 1'b0;
            disp_valid_q <= disp_req;

            // Pending access sequencing.
            unique case (pend_q)
                PendWrite: begin
                    if (!disp_req) pend_q <= PendIdle;
                end
                PendRead: begin
                    if (!disp_req) begin
                        pend_q <= PendRdWait;
                        addr_q <= addr_inc;
                    end
                end
                PendRdWait: begin
                    // The issue cycle belonged to the CPU, so capture even under disp_req.
                    readahead_q <= vram_rdata;
                    dout_q      <= vram_rdata;
                    pend_q      <= PendIdle;
                end
                default: ;
            endcase

            // CPU tick decode; a write takes precedence over a simultaneous read.
            if (wr_tick) begin
                if (mode) begin
                    if (!latch_q) begin
                        tmp_q   <= din;
                        latch_q <= 1'b1;
                    end else begin
                        latch_q <= 1'b0;
                        if (din[7]) begin
                            reg_we_q   <= 1'b1;
                            reg_num_q  <= din[2:0];
                            reg_data_q <= tmp_q;
                        end else if (busy) begin
                            // Changing addr now would corrupt the pending access.
                            overrun_q <= 1'b1;
                        end else begin
                            addr_q <= set_addr;
                            if (!din[6]) pend_q <= PendRead;
                        end
                    end
                end else if (busy) begin
                    overrun_q <= 1'b1;
                end else begin
                    latch_q     <= 1'b0;
                    readahead_q <= din;
                    dout_q      <= din;
                    waddr_q     <= addr_q;
                    wdata_q     <= din;
                    addr_q      <= addr_inc;
                    pend_q      <= PendWrite;
                end
            end else if (rd_tick) begin
                if (mode) begin
                    dout_q      <= status_in;
                    status_rd_q <= 1'b1;
                    latch_q     <= 1'b0;
                end else if (busy) begin
                    overrun_q <= 1'b1;
                end else begin
                    // dout already holds the read-ahead byte; fetch the next one.
                    latch_q <= 1'b0;
                    pend_q  <= PendRead;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp99_vram_sched.sv
module tb_vdp99_vram_sched;

    localparam int ADDR_W = 14;

    logic              pxclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_tick = 1'b0;
    logic              rd_tick = 1'b0;
    logic              mode = 1'b0;
    logic [7:0]        din = 8'h00;
    logic [7:0]        dout;
    logic [7:0]        status_in = 8'h00;
    logic              status_rd;
    logic              reg_we;
    logic [2:0]        reg_num;
    logic [7:0]        reg_data;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = 14'h2000;
    logic              disp_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [7:0]        vram_wdata;
    logic [7:0]        vram_rdata = 8'h00;
    logic              cpu_busy;
    logic              overrun;

    int tests = 0;
    int fails = 0;

    logic [21:0] wr_q[$];   // {addr, data} of expected VRAM writes
    logic [10:0] reg_q[$];  // {num, data} of expected register writes
    logic [7:0]  stat_q[$]; // expected dout after a status read
    logic        ovr_q[$];  // one entry per expected overrun pulse

    vdp99_vram_sched #(.ADDR_W(ADDR_W)) dut (
        .pxclk      (pxclk),
        .reset_n    (reset_n),
        .wr_tick    (wr_tick),
        .rd_tick    (rd_tick),
        .mode       (mode),
        .din        (din),
        .dout       (dout),
        .status_in  (status_in),
        .status_rd  (status_rd),
        .reg_we     (reg_we),
        .reg_num    (reg_num),
        .reg_data   (reg_data),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .cpu_busy   (cpu_busy),
        .overrun    (overrun)
    );

    always #5 pxclk = ~pxclk;

    // Read-only VRAM contents; writes are checked by the scoreboard instead.
    function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
        if (a == 14'h1234) return 8'hAB;
        if (a == 14'h1235) return 8'hCD;
        return 8'h00;
    endfunction

    always @(posedge pxclk) vram_rdata <= rom(vram_addr);

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge pxclk) begin
        if (reset_n) begin
            if (vram_we) begin
                if (wr_q.size() == 0) chk("unexpected vram_we", {vram_addr, vram_wdata}, 0);
                else chk("vram write {addr,data}", {vram_addr, vram_wdata}, wr_q.pop_front());
            end
            if (reg_we) begin
                if (reg_q.size() == 0) chk("unexpected reg_we", {reg_num, reg_data}, 0);
                else chk("reg write {num,data}", {reg_num, reg_data}, reg_q.pop_front());
            end
            if (status_rd) begin
                if (stat_q.size() == 0) chk("unexpected status_rd", dout, 0);
                else chk("status read dout", dout, stat_q.pop_front());
            end
            if (overrun) begin
                if (ovr_q.size() == 0) chk("unexpected overrun", 1, 0);
                else chk("overrun pulse", 1, 32'(ovr_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pxclk);
        #1;
    endtask

    task automatic tick(input logic w, input logic m, input logic [7:0] d);
        wr_tick = w;
        rd_tick = ~w;
        mode    = m;
        din     = d;
        step(1);
        wr_tick = 1'b0;
        rd_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(3);
        chk("reset dout", dout, 0);
        chk("reset cpu_busy", cpu_busy, 0);
        chk("reset vram_we", vram_we, 0);
        chk("reset disp_valid", disp_valid, 0);
        reset_n = 1'b1;
        step(1);

        // Set address 0x1234 with read-ahead
        tick(1, 1, 8'h34);
        tick(1, 1, 8'h12);
        chk("readahead busy T+1", cpu_busy, 1);
        chk("readahead vram_addr", vram_addr, 14'h1234);
        step(1);
        chk("readahead busy T+2", cpu_busy, 1);
        step(1);
        chk("readahead dout", dout, 8'hAB);
        chk("readahead busy done", cpu_busy, 0);
        tick(0, 0, 8'h00);
        chk("data read dout held", dout, 8'hAB);
        chk("data read vram_addr", vram_addr, 14'h1235);
        step(2);
        chk("data read prefetch", dout, 8'hCD);

        // Register write leaves addr alone
        reg_q.push_back({3'd7, 8'h07});
        tick(1, 1, 8'h07);
        tick(1, 1, 8'h87);
        step(1);
        tick(0, 0, 8'h00);
        chk("addr kept after reg write", vram_addr, 14'h1236);
        step(2);

        // Address wrap at 0x3FFF
        tick(1, 1, 8'hFF);
        tick(1, 1, 8'h7F);
        wr_q.push_back({14'h3FFF, 8'h11});
        tick(1, 0, 8'h11);
        step(3);
        wr_q.push_back({14'h0000, 8'h22});
        tick(1, 0, 8'h22);
        chk("data write dout", dout, 8'h22);
        step(2);

        // Display holds off a pending write for 10 cycles
        disp_req = 1'b1;
        wr_q.push_back({14'h0001, 8'h5A});
        tick(1, 0, 8'h5A);
        for (int i = 0; i < 9; i++) begin
            chk("held vram_we", vram_we, 0);
            chk("held vram_addr", vram_addr, 14'h2000);
            chk("held disp_valid", disp_valid, 1);
            step(1);
        end
        disp_req = 1'b0;
        #1;
        chk("release vram_we", vram_we, 1);
        chk("release disp_valid lag", disp_valid, 1);
        step(1);
        chk("disp_valid falls", disp_valid, 0);
        chk("write done busy", cpu_busy, 0);

        // Back-to-back data writes under display: second dropped
        disp_req = 1'b1;
        wr_q.push_back({14'h0002, 8'h77});
        tick(1, 0, 8'h77);
        ovr_q.push_back(1'b1);
        tick(1, 0, 8'h88);
        disp_req = 1'b0;
        step(2);
        wr_q.push_back({14'h0003, 8'h99});
        tick(1, 0, 8'h99);
        step(2);

        // Status read clears the latch
        tick(1, 1, 8'h55);
        status_in = 8'h80;
        stat_q.push_back(8'h80);
        tick(0, 1, 8'h00);
        chk("status dout", dout, 8'h80);
        tick(1, 1, 8'h05);
        tick(1, 1, 8'h40);
        chk("fresh pair no read", cpu_busy, 0);
        wr_q.push_back({14'h0005, 8'h66});
        tick(1, 0, 8'h66);
        step(2);

        // Reset during a pending write
        disp_req = 1'b1;
        tick(1, 0, 8'hEE);
        chk("pending before reset", cpu_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("reset vram_we", vram_we, 0);
        chk("reset busy", cpu_busy, 0);
        chk("reset dout 2", dout, 0);
        chk("reset reg", {reg_num, reg_data}, 0);
        chk("reset disp_valid 2", disp_valid, 0);
        disp_req = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);

        chk("writes left", wr_q.size(), 0);
        chk("reg writes left", reg_q.size(), 0);
        chk("status reads left", stat_q.size(), 0);
        chk("overruns left", ovr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
